// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART ALU packet protocol (initiator and responder).
package uart_alu_pkg;

   localparam logic [7:0] OpEcho = 8'hEC;
   localparam logic [7:0] OpAdd  = 8'h10;
   localparam logic [7:0] OpMul  = 8'h11;
   localparam logic [7:0] OpDiv  = 8'h12;

   localparam int unsigned HeaderBytes = 32'd4;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StSend = 2'd1,
      StResp = 2'd2,
      StDone = 2'd3
   } state_e;

   typedef struct packed {
      logic [7:0] tx_len;   // total packet length, header included
      logic [3:0] rx_cnt;   // reply bytes expected
   } op_info_t;

   // Packet length and reply size per opcode; zero for unsupported opcodes.
   function automatic op_info_t op_info(input logic [7:0] op);
      op_info_t info;
      case (op)
         OpEcho: begin
            info.tx_len = 8'(HeaderBytes + 32'd4);
            info.rx_cnt = 4'd4;
         end
         OpAdd, OpMul: begin
            info.tx_len = 8'(HeaderBytes + 32'd8);
            info.rx_cnt = 4'd4;
         end
         OpDiv: begin
            info.tx_len = 8'(HeaderBytes + 32'd8);
            info.rx_cnt = 4'd8;
         end
         default: begin
            info.tx_len = 8'd0;
            info.rx_cnt = 4'd0;
         end
      endcase
      return info;
   endfunction

   function automatic logic op_supported(input logic [7:0] op);
      case (op)
         OpEcho, OpAdd, OpMul, OpDiv: return 1'b1;
         default:                     return 1'b0;
      endcase
   endfunction

   // Byte idx of the framed packet: opcode, 0x00, length LSB first, A then B little-endian.
   function automatic logic [7:0] pkt_byte(input logic [7:0]  op,
                                           input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [7:0]  len,
                                           input logic [3:0]  idx);
      case (idx)
         4'd0:    return op;
         4'd1:    return 8'h00;
         4'd2:    return len;
         4'd3:    return 8'h00;
         4'd4:    return a[7:0];
         4'd5:    return a[15:8];
         4'd6:    return a[23:16];
         4'd7:    return a[31:24];
         4'd8:    return b[7:0];
         4'd9:    return b[15:8];
         4'd10:   return b[23:16];
         4'd11:   return b[31:24];
         default: return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/uart_alu_initiator.sv
// Host-side initiator: frames one ALU command onto the TX byte stream and
// assembles the responder's reply into a 64-bit result with status flags.
module uart_alu_initiator
   import uart_alu_pkg::*;
#(
   parameter int unsigned TimeoutCycles = 32'd2000000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [7:0]  cmd_op_i,
   input  logic [31:0] cmd_a_i,
   input  logic [31:0] cmd_b_i,
   output logic [7:0]  m_axis_tdata_o,
   output logic        m_axis_tvalid_o,
   input  logic        m_axis_tready_i,
   input  logic [7:0]  s_axis_tdata_i,
   input  logic        s_axis_tvalid_i,
   output logic        s_axis_tready_o,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [63:0] rsp_data_o,
   output logic        rsp_err_o,
   output logic        rsp_timeout_o,
   output logic        stray_o
);

   localparam logic        TmoEn   = (TimeoutCycles != 32'd0);
   localparam logic [31:0] TmoLast = TmoEn ? 32'(TimeoutCycles - 32'd1) : 32'd0;

   state_e      state_r, state_s;
   logic [7:0]  op_r;
   logic [31:0] a_r, b_r;
   logic [3:0]  tx_cnt_r, rx_cnt_r;
   logic [31:0] tmo_r;
   logic [7:0]  tdata_r;
   logic [63:0] rsp_data_r;
   logic        err_r, timeout_r, stray_r;
   op_info_t    info_s;
   logic        cmd_ok_s, tx_last_s, rx_last_s, tmo_hit_s;
   logic        cmd_ready_s, tvalid_s, rsp_valid_s;

   assign info_s    = op_info(op_r);
   assign cmd_ok_s  = op_supported(cmd_op_i);
   assign tx_last_s = (tx_cnt_r == 4'(info_s.tx_len - 8'd1));
   assign rx_last_s = (rx_cnt_r == (info_s.rx_cnt - 4'd1));
   assign tmo_hit_s = TmoEn && (tmo_r == TmoLast);

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r <= StIdle;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode; a final reply byte takes priority over timeout expiry.
   always_comb begin
      state_s = state_r;
      case (state_r)
         StIdle: begin
            if (cmd_valid_i) begin
               if (cmd_ok_s) state_s = StSend;
               else          state_s = StDone;
            end else begin
               state_s = StIdle;
            end
         end
         StSend: begin
            if (m_axis_tready_i && tx_last_s) state_s = StResp;
            else                              state_s = StSend;
         end
         StResp: begin
            if (s_axis_tvalid_i && rx_last_s) state_s = StDone;
            else if (tmo_hit_s)               state_s = StDone;
            else                              state_s = StResp;
         end
         StDone: begin
            if (rsp_ready_i) state_s = StIdle;
            else             state_s = StDone;
         end
         default: state_s = StIdle;
      endcase
   end

   // Handshake outputs decoded purely from the state register.
   always_comb begin
      cmd_ready_s = 1'b0;
      tvalid_s    = 1'b0;
      rsp_valid_s = 1'b0;
      case (state_r)
         StIdle:  cmd_ready_s = 1'b1;
         StSend:  tvalid_s    = 1'b1;
         StResp:  cmd_ready_s = 1'b0;
         StDone:  rsp_valid_s = 1'b1;
         default: cmd_ready_s = 1'b0;
      endcase
   end

   // Datapath: command latch, TX byte pipeline, reply assembly, timeout and stray flag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         op_r       <= 8'h00;
         a_r        <= 32'd0;
         b_r        <= 32'd0;
         tx_cnt_r   <= 4'd0;
         rx_cnt_r   <= 4'd0;
         tmo_r      <= 32'd0;
         tdata_r    <= 8'h00;
         rsp_data_r <= 64'd0;
         err_r      <= 1'b0;
         timeout_r  <= 1'b0;
         stray_r    <= 1'b0;
      end else begin
         stray_r <= s_axis_tvalid_i && (state_r != StResp);
         case (state_r)
            StIdle: begin
               if (cmd_valid_i) begin
                  op_r       <= cmd_op_i;
                  a_r        <= cmd_a_i;
                  b_r        <= cmd_b_i;
                  rsp_data_r <= 64'd0;
                  err_r      <= !cmd_ok_s;
                  timeout_r  <= 1'b0;
                  tx_cnt_r   <= 4'd0;
                  tdata_r    <= cmd_ok_s ? cmd_op_i : 8'h00;
               end
            end
            StSend: begin
               if (m_axis_tready_i) begin
                  if (tx_last_s) begin
                     rx_cnt_r <= 4'd0;
                     tmo_r    <= 32'd0;
                     tdata_r  <= 8'h00;
                  end else begin
                     tx_cnt_r <= tx_cnt_r + 4'd1;
                     tdata_r  <= pkt_byte(op_r, a_r, b_r, info_s.tx_len, tx_cnt_r + 4'd1);
                  end
               end
            end
            StResp: begin
               tmo_r <= tmo_r + 32'd1;
               if (s_axis_tvalid_i) begin
                  rsp_data_r[{rx_cnt_r[2:0], 3'b000} +: 8] <= s_axis_tdata_i;
                  rx_cnt_r <= rx_cnt_r + 4'd1;
               end
               if (tmo_hit_s && !(s_axis_tvalid_i && rx_last_s)) begin
                  timeout_r <= 1'b1;
               end
            end
            StDone: begin
               if (rsp_ready_i) begin
                  err_r     <= 1'b0;
                  timeout_r <= 1'b0;
               end
            end
            default: begin
               tx_cnt_r <= 4'd0;
               rx_cnt_r <= 4'd0;
            end
         endcase
      end
   end

   assign cmd_ready_o     = cmd_ready_s;
   assign m_axis_tvalid_o = tvalid_s;
   assign m_axis_tdata_o  = tdata_r;
   assign s_axis_tready_o = 1'b1;
   assign rsp_valid_o     = rsp_valid_s;
   assign rsp_data_o      = rsp_data_r;
   assign rsp_err_o       = err_r;
   assign rsp_timeout_o   = timeout_r;
   assign stray_o         = stray_r;

endmodule

// File: tb/tb_uart_alu_initiator.sv
// Scoreboard bench for uart_alu_initiator with an in-bench responder model.
module tb_uart_alu_initiator;

   localparam int unsigned Tmo = 50;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        cmd_valid_i, cmd_ready_o;
   logic [7:0]  cmd_op_i;
   logic [31:0] cmd_a_i, cmd_b_i;
   logic [7:0]  m_axis_tdata_o;
   logic        m_axis_tvalid_o, m_axis_tready_i;
   logic [7:0]  s_axis_tdata_i;
   logic        s_axis_tvalid_i, s_axis_tready_o;
   logic        rsp_valid_o, rsp_ready_i;
   logic [63:0] rsp_data_o;
   logic        rsp_err_o, rsp_timeout_o, stray_o;

   typedef struct packed {
      logic [63:0] data;
      logic        err;
      logic        tmo;
   } rsp_t;

   int   n_cmp = 0;
   int   n_fail = 0;
   logic [7:0] tx_exp_q[$];
   rsp_t       rsp_exp_q[$];
   logic [7:0] pkt_q[$];
   logic [7:0] reply_q[$];
   logic [7:0] ovr_q[$];
   bit   ovr_en = 1'b0;
   int   tready_mode = 0;
   int   stray_req = 0;
   int   tx_seen = 0;
   int   stray_cnt = 0;

   always #5 clk_i = ~clk_i;

   uart_alu_initiator #(.TimeoutCycles(Tmo)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_op_i(cmd_op_i), .cmd_a_i(cmd_a_i), .cmd_b_i(cmd_b_i),
      .m_axis_tdata_o(m_axis_tdata_o), .m_axis_tvalid_o(m_axis_tvalid_o),
      .m_axis_tready_i(m_axis_tready_i),
      .s_axis_tdata_i(s_axis_tdata_i), .s_axis_tvalid_i(s_axis_tvalid_i),
      .s_axis_tready_o(s_axis_tready_o),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
      .rsp_timeout_o(rsp_timeout_o), .stray_o(stray_o)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic bit is_op(input logic [7:0] op);
      return (op == 8'hEC) || (op == 8'h10) || (op == 8'h11) || (op == 8'h12);
   endfunction

   // What the ALU computes, as plain arithmetic.
   function automatic logic [63:0] alu(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      case (op)
         8'h10:   begin r = a + b; return {32'd0, r}; end
         8'h11:   begin r = a * b; return {32'd0, r}; end
         8'h12:   return {a % b, a / b};
         8'hEC:   return {32'd0, a};
         default: return 64'd0;
      endcase
   endfunction

   function automatic rsp_t exp_of(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
      rsp_t e;
      if (is_op(op)) begin e.data = alu(op, a, b); e.err = 1'b0; end
      else           begin e.data = 64'd0;         e.err = 1'b1; end
      e.tmo = 1'b0;
      return e;
   endfunction

   // Transmitter-side ready pattern: always, toggling, or random.
   initial begin
      m_axis_tready_i = 1'b0;
      forever begin
         @(posedge clk_i); #2;
         case (tready_mode)
            0:       m_axis_tready_i = 1'b1;
            1:       m_axis_tready_i = ~m_axis_tready_i;
            default: m_axis_tready_i = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Receiver-side driver: stray bytes on request, otherwise queued reply bytes.
   initial begin
      int stray_done;
      stray_done = 0;
      s_axis_tvalid_i = 1'b0;
      s_axis_tdata_i  = 8'h00;
      forever begin
         @(posedge clk_i); #2;
         if (stray_req != stray_done) begin
            stray_done++;
            s_axis_tvalid_i = 1'b1;
            s_axis_tdata_i  = 8'h77;
         end else if (reply_q.size() > 0) begin
            s_axis_tvalid_i = 1'b1;
            s_axis_tdata_i  = reply_q.pop_front();
         end else begin
            s_axis_tvalid_i = 1'b0;
         end
      end
   end

   // TX monitor: byte check, stall stability, and responder model on packet completion.
   initial begin
      logic        prev_stall;
      logic [7:0]  prev_data, op;
      logic [31:0] a, b;
      logic [63:0] res;
      int          n;
      prev_stall = 1'b0;
      prev_data  = 8'h00;
      forever begin
         @(negedge clk_i);
         if (!rst_ni) begin
            pkt_q.delete();
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("tx_hold_valid", 64'(m_axis_tvalid_o), 64'd1);
               check("tx_hold_data", 64'(m_axis_tdata_o), 64'(prev_data));
            end
            if (m_axis_tvalid_o && m_axis_tready_i) begin
               tx_seen++;
               if (tx_exp_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL tx_unexpected: got byte 0x%0h, expected no byte", m_axis_tdata_o);
               end else begin
                  check("tx_byte", 64'(m_axis_tdata_o), 64'(tx_exp_q.pop_front()));
               end
               pkt_q.push_back(m_axis_tdata_o);
               if (pkt_q.size() >= 4 && pkt_q.size() == int'(pkt_q[2])) begin
                  op = pkt_q[0];
                  a  = {pkt_q[7], pkt_q[6], pkt_q[5], pkt_q[4]};
                  b  = (pkt_q.size() == 12) ? {pkt_q[11], pkt_q[10], pkt_q[9], pkt_q[8]} : 32'd0;
                  if (ovr_en) begin
                     foreach (ovr_q[i]) reply_q.push_back(ovr_q[i]);
                  end else begin
                     res = alu(op, a, b);
                     n   = (op == 8'h12) ? 8 : 4;
                     for (int i = 0; i < n; i++) reply_q.push_back(res[8*i +: 8]);
                  end
                  pkt_q.delete();
               end
            end
            prev_stall = m_axis_tvalid_o && !m_axis_tready_i;
            prev_data  = m_axis_tdata_o;
         end
      end
   end

   // Response monitor: scoreboard pop on handshake, hold stability, stray pulse count.
   initial begin
      logic        prev_hold, pe, pt;
      logic [63:0] pd;
      rsp_t        e;
      prev_hold = 1'b0;
      forever begin
         @(negedge clk_i);
         if (!rst_ni) begin
            prev_hold = 1'b0;
         end else begin
            if (prev_hold) begin
               check("rsp_hold_valid", 64'(rsp_valid_o), 64'd1);
               check("rsp_hold_data", rsp_data_o, pd);
               check("rsp_hold_flags", {62'd0, rsp_err_o, rsp_timeout_o}, {62'd0, pe, pt});
            end
            if (rsp_valid_o && rsp_ready_i) begin
               if (rsp_exp_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL rsp_unexpected: got data 0x%0h, expected no response", rsp_data_o);
               end else begin
                  e = rsp_exp_q.pop_front();
                  check("rsp_data", rsp_data_o, e.data);
                  check("rsp_err", 64'(rsp_err_o), 64'(e.err));
                  check("rsp_timeout", 64'(rsp_timeout_o), 64'(e.tmo));
               end
            end
            prev_hold = rsp_valid_o && !rsp_ready_i;
            pd = rsp_data_o;
            pe = rsp_err_o;
            pt = rsp_timeout_o;
            if (stray_o) stray_cnt++;
         end
      end
   end

   task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b, input rsp_t e);
      bit acc;
      if (is_op(op)) begin
         tx_exp_q.push_back(op);
         tx_exp_q.push_back(8'h00);
         tx_exp_q.push_back((op == 8'hEC) ? 8'd8 : 8'd12);
         tx_exp_q.push_back(8'h00);
         for (int i = 0; i < 4; i++) tx_exp_q.push_back(a[8*i +: 8]);
         if (op != 8'hEC) for (int i = 0; i < 4; i++) tx_exp_q.push_back(b[8*i +: 8]);
      end
      rsp_exp_q.push_back(e);
      @(posedge clk_i); #1;
      cmd_valid_i = 1'b1;
      cmd_op_i = op;
      cmd_a_i  = a;
      cmd_b_i  = b;
      acc = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk_i);
         if (cmd_ready_o) begin acc = 1'b1; break; end
      end
      if (!acc) begin
         n_cmp++;
         n_fail++;
         $display("FAIL cmd_accept: got cmd_ready_o=0 for 200 cycles, expected 1");
      end
      @(posedge clk_i); #1;
      cmd_valid_i = 1'b0;
      cmd_op_i = 8'($urandom);
      cmd_a_i  = $urandom;
      cmd_b_i  = $urandom;
   endtask

   task automatic wait_rsp(input int hold);
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk_i); #1;
         if (rsp_exp_q.size() == 0) begin
            rsp_ready_i = 1'b0;
            return;
         end
         rsp_ready_i = (c >= hold) && ($urandom_range(0, 3) != 0);
      end
      n_cmp++;
      n_fail++;
      $display("FAIL rsp_wait: got %0d responses outstanding after 3000 cycles, expected 0", rsp_exp_q.size());
      rsp_exp_q.delete();
      tx_exp_q.delete();
      rsp_ready_i = 1'b0;
   endtask

   initial begin
      logic [7:0]  op;
      logic [31:0] a, b;
      int          base;
      logic [7:0]  ops [5];
      rsp_t        e;
      ops = '{8'h10, 8'h11, 8'h12, 8'hEC, 8'h55};
      rst_ni = 1'b0;
      cmd_valid_i = 1'b0;
      cmd_op_i = 8'h00;
      cmd_a_i  = 32'd0;
      cmd_b_i  = 32'd0;
      rsp_ready_i = 1'b0;
      repeat (3) @(negedge clk_i);
      check("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
      check("rst_tvalid", 64'(m_axis_tvalid_o), 64'd0);
      check("rst_tdata", 64'(m_axis_tdata_o), 64'd0);
      check("rst_s_tready", 64'(s_axis_tready_o), 64'd1);
      check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
      check("rst_rsp_data", rsp_data_o, 64'd0);
      check("rst_rsp_err", 64'(rsp_err_o), 64'd0);
      check("rst_rsp_timeout", 64'(rsp_timeout_o), 64'd0);
      check("rst_stray", 64'(stray_o), 64'd0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;

      // ADD 5+3 with a always-ready transmitter.
      tready_mode = 0;
      issue(8'h10, 32'd5, 32'd3, '{64'h8, 1'b0, 1'b0});
      wait_rsp(0);

      // DIV 100/7 -> quotient 14, remainder 2.
      tready_mode = 2;
      issue(8'h12, 32'd100, 32'd7, '{64'h00000002_0000000E, 1'b0, 1'b0});
      wait_rsp(0);

      // ECHO with the transmitter stalling every other cycle.
      tready_mode = 1;
      issue(8'hEC, 32'hDEADBEEF, 32'h12345678, '{64'hDEADBEEF, 1'b0, 1'b0});
      wait_rsp(0);

      // Unsupported opcode: straight to DONE, held for 10 cycles of backpressure.
      tready_mode = 0;
      issue(8'h55, 32'd1, 32'd2, '{64'd0, 1'b1, 1'b0});
      @(negedge clk_i);
      check("err_done_next", 64'(rsp_valid_o), 64'd1);
      wait_rsp(10);

      // MUL with a truncated reply: timeout keeps the two bytes received.
      ovr_q = '{8'hAA, 8'hBB};
      ovr_en = 1'b1;
      issue(8'h11, $urandom, $urandom, '{64'hBBAA, 1'b0, 1'b1});
      wait_rsp(0);
      ovr_en = 1'b0;

      // Stray byte while idle.
      base = stray_cnt;
      @(posedge clk_i); #1;
      stray_req++;
      repeat (4) @(negedge clk_i);
      check("stray_pulse", 64'(stray_cnt - base), 64'd1);

      // Reset after 5 TX bytes, then a fresh packet.
      tready_mode = 0;
      base = tx_seen;
      issue(8'h10, 32'h11111111, 32'h22222222, '{64'h33333333, 1'b0, 1'b0});
      for (int i = 0; i < 100; i++) begin
         @(posedge clk_i); #1;
         if (tx_seen - base >= 5) break;
      end
      rst_ni = 1'b0;
      #1;
      check("mid_rst_tvalid", 64'(m_axis_tvalid_o), 64'd0);
      check("mid_rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
      check("mid_rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
      tx_exp_q.delete();
      rsp_exp_q.delete();
      @(negedge clk_i);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      a = $urandom;
      b = $urandom;
      issue(8'h10, a, b, exp_of(8'h10, a, b));
      wait_rsp(0);

      // Randomized commands with random transmitter and response backpressure.
      tready_mode = 2;
      for (int k = 0; k < 20; k++) begin
         op = ops[$urandom_range(0, 4)];
         if (op == 8'h55) op = 8'($urandom);
         a = $urandom;
         b = $urandom;
         if (op == 8'h12 && b == 32'd0) b = 32'd1;
         if ($urandom_range(0, 1) == 1) b = b >> $urandom_range(0, 31);
         if (op == 8'h12 && b == 32'd0) b = 32'd3;
         e = exp_of(op, a, b);
         issue(op, a, b, e);
         wait_rsp(0);
      end

      repeat (3) @(negedge clk_i);
      check("tx_queue_drained", 64'(tx_exp_q.size()), 64'd0);
      check("stray_total", 64'(stray_cnt), 64'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
